// File: rtl/image_display_sequencer.sv
// Pixel-domain playback sequencer: arms on start/auto_start, waits for the frame origin,
// then pops one FIFO word per window pixel and drives rgb one cycle after cx/cy.
module image_display_sequencer #(
  parameter int FRAME_WIDTH   = 2200,
  parameter int FRAME_HEIGHT  = 1125,
  parameter int SCREEN_WIDTH  = 1920,
  parameter int SCREEN_HEIGHT = 1080,
  parameter int BIT_WIDTH     = 12,
  parameter int BIT_HEIGHT    = 11,
  parameter int IMAGE_WIDTH   = 100,
  parameter int IMAGE_HEIGHT  = 100
) (
  input  logic                  clk_pixel,
  input  logic                  clk_pixel_reset,
  input  logic [BIT_WIDTH-1:0]  cx,
  input  logic [BIT_HEIGHT-1:0] cy,
  input  logic [63:0]           counter,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  auto_start,
  input  logic [63:0]           start_time,
  input  logic [BIT_WIDTH-1:0]  x_offset,
  input  logic [BIT_HEIGHT-1:0] y_offset,
  input  logic [15:0]           frame_count,
  input  logic [23:0]           fifo_dout,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  output logic [23:0]           rgb,
  output logic                  busy,
  output logic                  underflow,
  output logic                  cfg_error,
  output logic [15:0]           frames_done
);

  if (SCREEN_WIDTH > FRAME_WIDTH || SCREEN_HEIGHT > FRAME_HEIGHT ||
      FRAME_WIDTH > (1 << BIT_WIDTH) || FRAME_HEIGHT > (1 << BIT_HEIGHT)) begin : g_bad_params
    $error("image_display_sequencer: raster geometry does not fit cx/cy widths");
  end

  localparam logic [BIT_WIDTH:0]  IW_X = (BIT_WIDTH+1)'(IMAGE_WIDTH);
  localparam logic [BIT_WIDTH:0]  SW_X = (BIT_WIDTH+1)'(SCREEN_WIDTH);
  localparam logic [BIT_HEIGHT:0] IH_Y = (BIT_HEIGHT+1)'(IMAGE_HEIGHT);
  localparam logic [BIT_HEIGHT:0] SH_Y = (BIT_HEIGHT+1)'(SCREEN_HEIGHT);

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_WAIT_FRAME, S_DISPLAY} state_e;

  state_e                state_q, state_d;
  logic [BIT_WIDTH-1:0]  x_off_q, x_off_d;
  logic [BIT_HEIGHT-1:0] y_off_q, y_off_d;
  logic [15:0]           frame_count_q, frame_count_d;
  logic [63:0]           start_time_q, start_time_d;
  logic [15:0]           frames_done_q, frames_done_d;
  logic                  auto_mode_q, auto_mode_d;
  logic                  stop_pending_q, stop_pending_d;
  logic                  underflow_q, underflow_d;
  logic                  cfg_error_q, cfg_error_d;
  logic [23:0]           rgb_q, rgb_d;

  logic [BIT_WIDTH:0]  req_x_end, win_x_end;
  logic [BIT_HEIGHT:0] req_y_end, win_y_end;
  logic cfg_valid, in_window, last_pixel, at_origin, pixel_active, image_exit;

  assign req_x_end = {1'b0, x_offset} + IW_X;
  assign req_y_end = {1'b0, y_offset} + IH_Y;
  assign win_x_end = {1'b0, x_off_q} + IW_X;
  assign win_y_end = {1'b0, y_off_q} + IH_Y;
  assign cfg_valid = (req_x_end <= SW_X) && (req_y_end <= SH_Y);

  assign in_window  = (cx >= x_off_q) && ({1'b0, cx} < win_x_end) &&
                      (cy >= y_off_q) && ({1'b0, cy} < win_y_end);
  assign last_pixel = ({1'b0, cx} == win_x_end - 1'b1) && ({1'b0, cy} == win_y_end - 1'b1);
  assign at_origin  = (cx == '0) && (cy == '0);

  // The origin cycle seen in WAIT_FRAME is already a display pixel, unless stop aborts it.
  assign pixel_active = (state_q == S_DISPLAY) ||
                        ((state_q == S_WAIT_FRAME) && at_origin && !stop);

  assign image_exit = ((frame_count_q != '0) &&
                       (({1'b0, frames_done_q} + 17'd1) == {1'b0, frame_count_q})) ||
                      stop_pending_q || stop || (auto_mode_q && !auto_start);

  assign fifo_rd_en = !clk_pixel_reset && pixel_active && in_window && !fifo_empty;

  always_comb begin
    state_d        = state_q;
    x_off_d        = x_off_q;
    y_off_d        = y_off_q;
    frame_count_d  = frame_count_q;
    start_time_d   = start_time_q;
    frames_done_d  = frames_done_q;
    auto_mode_d    = auto_mode_q;
    stop_pending_d = stop_pending_q;
    underflow_d    = underflow_q;
    cfg_error_d    = 1'b0;
    rgb_d          = '0;

    if (pixel_active && in_window) begin
      if (fifo_empty) underflow_d = 1'b1;
      else            rgb_d       = fifo_dout;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (cfg_valid) begin
            x_off_d        = x_offset;
            y_off_d        = y_offset;
            frame_count_d  = frame_count;
            start_time_d   = start_time;
            frames_done_d  = '0;
            underflow_d    = 1'b0;
            auto_mode_d    = 1'b0;
            stop_pending_d = 1'b0;
            state_d        = S_ARMED;
          end else begin
            cfg_error_d = 1'b1;
          end
        end else if (auto_start) begin
          if (cfg_valid) begin
            x_off_d        = x_offset;
            y_off_d        = y_offset;
            frame_count_d  = '0;
            frames_done_d  = '0;
            auto_mode_d    = 1'b1;
            stop_pending_d = 1'b0;
            state_d        = S_WAIT_FRAME;
          end else begin
            cfg_error_d = 1'b1;
          end
        end
      end
      S_ARMED: begin
        if (stop)                            state_d = S_IDLE;
        else if (counter >= start_time_q)    state_d = S_WAIT_FRAME;
      end
      S_WAIT_FRAME: begin
        if (stop)           state_d = S_IDLE;
        else if (at_origin) state_d = S_DISPLAY;
      end
      S_DISPLAY: begin
        if (stop) stop_pending_d = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    // Exit is only taken on the last window pixel so a whole image is always consumed.
    if (pixel_active && last_pixel) begin
      if (frames_done_q != 16'hFFFF) frames_done_d = frames_done_q + 16'd1;
      if (image_exit) state_d = S_IDLE;
    end

    if (state_d == S_IDLE) stop_pending_d = 1'b0;
  end

  always_ff @(posedge clk_pixel) begin
    if (clk_pixel_reset) begin
      state_q        <= S_IDLE;
      x_off_q        <= '0;
      y_off_q        <= '0;
      frame_count_q  <= '0;
      start_time_q   <= '0;
      frames_done_q  <= '0;
      auto_mode_q    <= 1'b0;
      stop_pending_q <= 1'b0;
      underflow_q    <= 1'b0;
      cfg_error_q    <= 1'b0;
      rgb_q          <= '0;
    end else begin
      state_q        <= state_d;
      x_off_q        <= x_off_d;
      y_off_q        <= y_off_d;
      frame_count_q  <= frame_count_d;
      start_time_q   <= start_time_d;
      frames_done_q  <= frames_done_d;
      auto_mode_q    <= auto_mode_d;
      stop_pending_q <= stop_pending_d;
      underflow_q    <= underflow_d;
      cfg_error_q    <= cfg_error_d;
      rgb_q          <= rgb_d;
    end
  end

  assign rgb         = rgb_q;
  assign busy        = (state_q != S_IDLE);
  assign underflow   = underflow_q;
  assign cfg_error   = cfg_error_q;
  assign frames_done = frames_done_q;

endmodule

// File: tb/tb_image_display_sequencer.sv
// Bench for image_display_sequencer on a shrunken raster; expectations come from a
// frame-level playback plan (which frames play, where windows fall) plus a FIFO queue.
module tb_image_display_sequencer;
  localparam int FW = 40, FH = 30, SW = 32, SH = 24, BW = 12, BH = 11, IW = 8, IH = 6;
  localparam longint FPIX = FW * FH;
  localparam longint NEVER = longint'(1) << 60;

  logic          clk = 1'b0;
  logic          rst;
  logic [BW-1:0] cx;
  logic [BH-1:0] cy;
  logic [63:0]   counter;
  logic          start, stop, auto_start;
  logic [63:0]   start_time;
  logic [BW-1:0] x_offset;
  logic [BH-1:0] y_offset;
  logic [15:0]   frame_count;
  logic [23:0]   fifo_dout;
  logic          fifo_empty;
  logic          fifo_rd_en;
  logic [23:0]   rgb;
  logic          busy, underflow, cfg_error;
  logic [15:0]   frames_done;

  image_display_sequencer #(
    .FRAME_WIDTH(FW), .FRAME_HEIGHT(FH), .SCREEN_WIDTH(SW), .SCREEN_HEIGHT(SH),
    .BIT_WIDTH(BW), .BIT_HEIGHT(BH), .IMAGE_WIDTH(IW), .IMAGE_HEIGHT(IH)
  ) dut (
    .clk_pixel(clk), .clk_pixel_reset(rst), .cx(cx), .cy(cy), .counter(counter),
    .start(start), .stop(stop), .auto_start(auto_start), .start_time(start_time),
    .x_offset(x_offset), .y_offset(y_offset), .frame_count(frame_count),
    .fifo_dout(fifo_dout), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
    .rgb(rgb), .busy(busy), .underflow(underflow), .cfg_error(cfg_error),
    .frames_done(frames_done)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  int unsigned vectors = 0, miscompares = 0;
  longint n = 0;
  int dut_pops = 0;
  logic [23:0] fifo_q[$];

  // Playback plan: accepted at m_s, frames m_k0..m_k1 play, last busy cycle m_last.
  bit     m_on = 0;
  longint m_s = 0, m_k0 = 0, m_k1 = 0, m_last = 0;
  int     m_xo = 0, m_yo = 0, m_fd = 0;
  bit     m_uf = 0, exp_cfg = 0;

  function automatic longint end_cycle(longint k);
    return k * FPIX + longint'(m_yo + IH - 1) * FW + m_xo + IW - 1;
  endfunction

  function automatic bit window_slot(longint c);
    longint f, rel, x, y;
    if (!m_on) return 1'b0;
    f = c / FPIX; rel = c % FPIX; x = rel % FW; y = rel / FW;
    return (f >= m_k0) && (f <= m_k1) && (x >= m_xo) && (x < m_xo + IW) &&
           (y >= m_yo) && (y < m_yo + IH);
  endfunction

  function automatic bit model_busy_at(longint c);
    return m_on && (c > m_s) && (c <= m_last);
  endfunction

  function automatic bit offsets_ok(int xo, int yo);
    return (xo + IW <= SW) && (yo + IH <= SH);
  endfunction

  task automatic set_end(input longint p);
    longint f, k;
    if (p <= m_k0 * FPIX) begin
      m_k1 = m_k0 - 1; m_last = p;
    end else begin
      f = p / FPIX;
      k = (p <= end_cycle(f)) ? f : f + 1;
      if (k < m_k1) m_k1 = k;
      m_last = end_cycle(m_k1);
    end
  endtask

  task automatic load(input int words);
    repeat (words) fifo_q.push_back(24'($urandom));
  endtask

  task automatic do_start(input int xo, input int yo, input int fc, input longint delay);
    longint t;
    x_offset = BW'(xo); y_offset = BH'(yo); frame_count = 16'(fc);
    start_time = 64'(n + delay); start = 1'b1;
    if (model_busy_at(n)) return;
    if (!offsets_ok(xo, yo)) begin exp_cfg = 1'b1; return; end
    t = (n + delay > n + 1) ? n + delay : n + 1;
    m_on = 1; m_s = n; m_xo = xo; m_yo = yo; m_fd = 0; m_uf = 0;
    m_k0 = (t + FPIX) / FPIX;
    m_k1 = (fc == 0) ? NEVER : m_k0 + fc - 1;
    m_last = (fc == 0) ? NEVER : end_cycle(m_k1);
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    if (model_busy_at(n)) set_end(n);
  endtask

  task automatic step();
    longint rel;
    bit exp_rd, got_rd, exp_busy;
    logic [23:0] exp_rgb;
    rel = n % FPIX;
    cx = BW'(rel % FW); cy = BH'(rel / FW); counter = 64'(n);
    fifo_empty = (fifo_q.size() == 0);
    fifo_dout = fifo_empty ? 24'($urandom) : fifo_q[0];
    if (!rst && auto_start && !start && !model_busy_at(n)) begin
      if (offsets_ok(int'(x_offset), int'(y_offset))) begin
        m_on = 1; m_s = n; m_xo = int'(x_offset); m_yo = int'(y_offset); m_fd = 0;
        m_k0 = (n + FPIX) / FPIX; m_k1 = NEVER; m_last = NEVER;
      end else exp_cfg = 1'b1;
    end
    #2;
    exp_rd = !rst && window_slot(n) && !fifo_empty;
    got_rd = fifo_rd_en;
    if (got_rd === 1'b1) dut_pops++;
    vectors++;
    if (got_rd !== exp_rd) begin
      miscompares++;
      $display("FAIL pop n=%0d cx=%0d cy=%0d got %b want %b", n, cx, cy, got_rd, exp_rd);
    end
    exp_rgb = '0;
    if (rst) begin
      m_on = 0; m_fd = 0; m_uf = 0;
    end else if (window_slot(n)) begin
      if (fifo_empty) m_uf = 1;
      else exp_rgb = fifo_q.pop_front();
      if (n == end_cycle(n / FPIX) && m_fd != 65535) m_fd++;
    end
    exp_busy = !rst && m_on && (n >= m_s) && (n + 1 <= m_last);
    @(posedge clk); #1;
    vectors++;
    if (rgb !== exp_rgb) begin
      miscompares++; $display("FAIL rgb n=%0d got %h want %h", n, rgb, exp_rgb);
    end
    vectors++;
    if (busy !== exp_busy) begin
      miscompares++; $display("FAIL busy n=%0d got %b want %b", n, busy, exp_busy);
    end
    vectors++;
    if (underflow !== m_uf) begin
      miscompares++; $display("FAIL underflow n=%0d got %b want %b", n, underflow, m_uf);
    end
    vectors++;
    if (frames_done !== 16'(m_fd)) begin
      miscompares++; $display("FAIL frames_done n=%0d got %0d want %0d", n, frames_done, m_fd);
    end
    vectors++;
    if (cfg_error !== exp_cfg) begin
      miscompares++; $display("FAIL cfg_error n=%0d got %b want %b", n, cfg_error, exp_cfg);
    end
    start = 1'b0; stop = 1'b0; exp_cfg = 1'b0;
    n++;
  endtask

  task automatic run_to(input longint target);
    while (n < target) step();
  endtask

  task automatic run_until_idle(input longint budget);
    longint lim;
    lim = n + budget;
    while (n <= m_last + 2 && n < lim) step();
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++; $display("FAIL idle_timeout n=%0d busy got %b want 0", n, busy);
    end
  endtask

  task automatic check_pops(input string name, input int want);
    vectors++;
    if (dut_pops !== want) begin
      miscompares++; $display("FAIL %s pops got %0d want %0d", name, dut_pops, want);
    end
  endtask

  task automatic test_reset();
    longint lim;
    rst = 1'b1; start = 0; stop = 0; auto_start = 0; start_time = '0;
    x_offset = '0; y_offset = '0; frame_count = '0;
    repeat (3) step();
    rst = 1'b0;
    load(200); dut_pops = 0;
    do_start(3, 2, 0, 0); step();
    lim = n + 3 * FPIX;
    while (dut_pops < 10 && n < lim) step();
    rst = 1'b1; repeat (4) step(); rst = 1'b0;
    dut_pops = 0;
    repeat (FPIX + 20) step();
    check_pops("after_reset", 0);
    fifo_q.delete();
  endtask

  task automatic test_timed_start();
    load(IW * IH); dut_pops = 0;
    do_start(10, 5, 1, 50 + longint'($urandom_range(0, 1200))); step();
    run_until_idle(4 * FPIX);
    check_pops("timed", IW * IH);
    vectors++;
    if (frames_done !== 16'd1) begin
      miscompares++; $display("FAIL timed frames_done got %0d want 1", frames_done);
    end
  endtask

  task automatic test_invalid_config();
    do_start(SW - IW + 1, 0, 1, 0); step(); step();
    do_start(0, SH - IH + 1, 1, 0); step();
    do_start((1 << BW) - 1, 0, 1, 0); step();
    x_offset = BW'(30); y_offset = '0; auto_start = 1'b1;
    repeat (3) step();
    auto_start = 1'b0; step();
    load(IW * IH); dut_pops = 0;
    do_start(SW - IW, SH - IH, 1, 0); step();
    run_until_idle(3 * FPIX);
    check_pops("edge_window", IW * IH);
  endtask

  task automatic test_underflow();
    load(IW * IH - 3); dut_pops = 0;
    do_start($urandom_range(0, SW - IW), $urandom_range(0, SH - IH), 1, 0); step();
    run_until_idle(3 * FPIX);
    check_pops("underflow", IW * IH - 3);
    vectors++;
    if (underflow !== 1'b1) begin
      miscompares++; $display("FAIL underflow_flag got %b want 1", underflow);
    end
  endtask

  task automatic test_stop();
    longint target;
    load(2 * IW * IH + 5); dut_pops = 0;
    do_start($urandom_range(0, SW - IW), $urandom_range(0, SH - IH - 1), 0, 0); step();
    target = (m_k0 + 1) * FPIX + longint'(m_yo + IH / 2) * FW;
    run_to(target - 1);
    do_start(0, 0, 7, 0); step();
    pulse_stop(); step();
    run_until_idle(3 * FPIX);
    check_pops("stop", 2 * IW * IH);
    vectors++;
    if (frames_done !== 16'd2) begin
      miscompares++; $display("FAIL stop frames_done got %0d want 2", frames_done);
    end
    fifo_q.delete();
  endtask

  task automatic test_auto_start();
    load(4 * IW * IH); dut_pops = 0;
    x_offset = '0; y_offset = '0; auto_start = 1'b1;
    step();
    run_to((m_k0 + 2) * FPIX + 2 * FW + 3);
    auto_start = 1'b0; set_end(n); step();
    run_until_idle(3 * FPIX);
    check_pops("auto", 3 * IW * IH);
    fifo_q.delete();
  endtask

  task automatic test_back_to_back();
    int fc, short_by;
    for (int i = 0; i < 3; i++) begin
      fc = $urandom_range(1, 2); short_by = $urandom_range(0, 2);
      load(fc * IW * IH - short_by); dut_pops = 0;
      pulse_stop();
      do_start($urandom_range(0, SW - IW), $urandom_range(0, SH - IH), fc,
               longint'($urandom_range(0, 400)));
      step();
      run_until_idle(5 * FPIX);
      check_pops("b2b", fc * IW * IH - short_by);
      vectors++;
      if (underflow !== (short_by != 0)) begin
        miscompares++; $display("FAIL b2b underflow got %b want %b", underflow, short_by != 0);
      end
      fifo_q.delete();
    end
  endtask

  initial begin
    test_reset();
    test_timed_start();
    test_invalid_config();
    test_underflow();
    test_stop();
    test_auto_start();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
